// File: rtl/db_arb_pkg.sv
// Shared types and constants for the data-break channel arbiter.
package db_arb_pkg;

  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned STATE_W  = 5;
  localparam int unsigned TCNT_W   = 12;

  // CPU major-state codes for the two data-break cycles
  localparam logic [STATE_W-1:0] CPU_DB1 = STATE_W'(6);
  localparam logic [STATE_W-1:0] CPU_DB2 = STATE_W'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BRK  = 2'd2,
    DONE = 2'd3
  } dbstate_t;

endpackage

// File: rtl/db_rr_pick.sv
// Combinational requester picker: first active request at or after rr_ptr,
// ascending with wrap. With rr_ptr = 0 this is plain lowest-index priority.
module db_rr_pick
  import db_arb_pkg::*;
#(
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Smallest rotated distance from rr_ptr among active requests wins
  always_comb begin
    int d;
    int best;
    int r;
    d     = 0;
    best  = int'(NREQ);
    r     = int'(rr_ptr);
    idx_c = '0;
    any_c = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      d = (i >= r) ? (i - r) : (i + int'(NREQ) - r);
      if (req[i] && (d < best)) begin
        best  = d;
        idx_c = IDX_W'(i);
        any_c = 1'b1;
      end
    end
  end

  // Expand winning index to one-hot
  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      onehot_c[i] = any_c && (idx_c == IDX_W'(i));
    end
  end

endmodule

// File: rtl/db_arbiter.sv
// Data-break (DMA) channel arbiter: shares the CPU break inputs among NREQ
// peripheral requesters, tracks DB1/DB2 and returns a per-requester done pulse.
// Build option: define DB_FIXED_PRIO_EN for fixed lowest-index priority;
// otherwise requesters are served round-robin.
module db_arbiter
  import db_arb_pkg::*;
#(
  parameter  int unsigned NREQ        = 2,
  parameter  int unsigned TIMEOUT_CYC = 4095,
  localparam int unsigned IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [STATE_W-1:0]           state,
  input  logic                         break_in_prog,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              req_to_dev,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic                         data_break,
  output logic                         to_disk,
  output logic [ADDR_W-1:0]            db_addr,
  output logic [DATA_W-1:0]            db_dout,
  output logic                         timeout_err
);

  dbstate_t          fsm;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TCNT_W-1:0] tcnt;
  logic              bip_q;
  logic              clr_pend;
  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              brk_end;
`ifndef DB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  own_idx;
`endif

  db_rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx),
    .any_c    (pick_any)
  );

  // CPU signals the end of the break either with DB2 or by dropping break_in_prog
  assign brk_end = (state == CPU_DB2) || (bip_q && !break_in_prog);

  // Break-cycle sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      rr_ptr      <= '0;
      tcnt        <= '0;
      bip_q       <= 1'b0;
      clr_pend    <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      data_break  <= 1'b0;
      to_disk     <= 1'b0;
      db_addr     <= '0;
      db_dout     <= '0;
      timeout_err <= 1'b0;
`ifndef DB_FIXED_PRIO_EN
      own_idx     <= '0;
`endif
    end else begin
      bip_q <= break_in_prog;
      done  <= '0;
      case (fsm)
        IDLE: begin
          if (clear) begin
            data_break  <= 1'b0;
            gnt         <= '0;
            timeout_err <= 1'b0;
          end else if (pick_any) begin
            gnt        <= pick_onehot;
            db_addr    <= req_addr[pick_idx];
            db_dout    <= req_data[pick_idx];
            to_disk    <= req_to_dev[pick_idx];
            data_break <= 1'b1;
            tcnt       <= '0;
            clr_pend   <= 1'b0;
`ifndef DB_FIXED_PRIO_EN
            own_idx    <= pick_idx;
`endif
            fsm        <= REQ;
          end
        end
        REQ: begin
          if (clear) begin
            data_break  <= 1'b0;
            gnt         <= '0;
            timeout_err <= 1'b0;
            fsm         <= IDLE;
          end else if (state == CPU_DB1) begin
            data_break <= 1'b0;
            fsm        <= BRK;
          end else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
            data_break  <= 1'b0;
            gnt         <= '0;
            timeout_err <= 1'b1;
            fsm         <= IDLE;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        BRK: begin
          // CPU is committed; a clear here is deferred until the cycle ends
          if (clear) clr_pend <= 1'b1;
          if (brk_end) begin
            done <= gnt;
            fsm  <= DONE;
          end
        end
        DONE: begin
          gnt      <= '0;
          clr_pend <= 1'b0;
          if (clr_pend || clear) timeout_err <= 1'b0;
`ifdef DB_FIXED_PRIO_EN
          rr_ptr <= '0;
`else
          rr_ptr <= (own_idx == IDX_W'(NREQ - 1)) ? '0 : own_idx + IDX_W'(1);
`endif
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Scoreboard bench for db_arbiter: directed requests push expected completions,
// a negedge monitor pops and checks them whenever done pulses.
module tb_db_arbiter;
  import db_arb_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        clear;
  logic [STATE_W-1:0]          cpu_state;
  logic                        bip;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_to_dev;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             done;
  logic                        data_break;
  logic                        to_disk;
  logic [ADDR_W-1:0]           db_addr;
  logic [DATA_W-1:0]           db_dout;
  logic                        timeout_err;

  db_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .state         (cpu_state),
    .break_in_prog (bip),
    .req           (req),
    .req_to_dev    (req_to_dev),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .gnt           (gnt),
    .done          (done),
    .data_break    (data_break),
    .to_disk       (to_disk),
    .db_addr       (db_addr),
    .db_dout       (db_dout),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic             dir;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   hi_cnt = 0;
  int   base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Count clocks with data_break asserted
  always @(negedge clk) if (data_break) hi_cnt <= hi_cnt + 1;

  // Completion monitor: every done pulse must match the next expected entry
  always @(negedge clk) begin
    if (!reset && (done != '0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%b gnt=%b, expected no completion", done, gnt);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", 32'(done), 32'(1 << e.idx));
        chk("gnt_owner", 32'(gnt), 32'(1 << e.idx));
        chk("db_addr", 32'(db_addr), 32'(e.addr));
        chk("db_dout", 32'(db_dout), 32'(e.data));
        chk("to_disk", 32'(to_disk), 32'(e.dir));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (data_break) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: data_break=%b after 40 clks, expected 1", data_break);
    end
  endtask

  // One full break cycle driven by a simple CPU model
  task automatic run_cycle(input int db1_dly, input bit use_bip, input bit clr_brk,
                           input bit scramble, input logic [NREQ-1:0] drop);
    bit ok;
    wait_grant(ok);
    if (!ok) return;
    req = req & ~drop;
    repeat (db1_dly) step();
    cpu_state = CPU_DB1;
    if (use_bip) bip = 1'b1;
    step();
    chk("db_low_in_brk", 32'(data_break), 32'(0));
    if (scramble) begin
      req_addr   = {15'o11111, 15'o22222};
      req_data   = {12'o3333, 12'o4444};
      req_to_dev = ~req_to_dev;
    end
    if (clr_brk) begin
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("brk_hold_on_clear", 32'(done), 32'(0));
    end
    if (use_bip) begin
      bip       = 1'b0;
      cpu_state = '0;
    end else begin
      cpu_state = CPU_DB2;
    end
    step();
    cpu_state = '0;
    step();
    chk("done_single_pulse", 32'(done), 32'(0));
  endtask

  task automatic do_timeout();
    bit ok;
    req[1] = 1'b1;
    base   = hi_cnt;
    wait_grant(ok);
    req[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!data_break) break;
    end
    chk("timeout_db_clks", 32'(hi_cnt - base), 32'(TO));
    chk("timeout_err_set", 32'(timeout_err), 32'(1));
    chk("timeout_gnt_clr", 32'(gnt), 32'(0));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    cpu_state  = '0;
    bip        = 1'b0;
    req        = '0;
    req_to_dev = '0;
    req_addr   = '0;
    req_data   = '0;
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_data_break", 32'(data_break), 32'(0));
    chk("rst_to_disk", 32'(to_disk), 32'(0));
    chk("rst_db_addr", 32'(db_addr), 32'(0));
    chk("rst_db_dout", 32'(db_dout), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset = 1'b0;
    step();

    // Both requesters held: round-robin alternates, fixed priority stays on 0
    req_addr[0] = 15'o00100; req_data[0] = 12'o1111; req_to_dev[0] = 1'b1;
    req_addr[1] = 15'o04321; req_data[1] = 12'o2222; req_to_dev[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef DB_FIXED_PRIO_EN
      sb.push_back('{0, 15'o00100, 12'o1111, 1'b1});
`else
      if (k % 2 == 0) sb.push_back('{0, 15'o00100, 12'o1111, 1'b1});
      else            sb.push_back('{1, 15'o04321, 12'o2222, 1'b0});
`endif
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) run_cycle(1, (k % 2) == 1, 1'b0, 1'b0, (k == 3) ? 2'b11 : 2'b00);
    step();

    // Single request, DB1 three clocks after grant: data_break high 4 clocks
    req_addr[0] = 15'o12345; req_data[0] = 12'o7070; req_to_dev[0] = 1'b0;
    sb.push_back('{0, 15'o12345, 12'o7070, 1'b0});
    base = hi_cnt;
    req  = 2'b01;
    run_cycle(3, 1'b0, 1'b0, 1'b0, 2'b01);
    chk("single_db_clks", 32'(hi_cnt - base), 32'(4));

    // No DB1: abandon after TIMEOUT_CYC clocks, no done
    do_timeout();

    // Clear during BRK: cycle completes, timeout_err cleared afterwards
    req_addr[1] = 15'o31416; req_data[1] = 12'o2716; req_to_dev[1] = 1'b1;
    sb.push_back('{1, 15'o31416, 12'o2716, 1'b1});
    req = 2'b10;
    run_cycle(2, 1'b0, 1'b1, 1'b0, 2'b10);
    chk("clr_brk_err_clr", 32'(timeout_err), 32'(0));

    // Clear during REQ: abort next clock, no done, timeout_err cleared
    do_timeout();
    begin
      bit ok;
      req = 2'b01;
      wait_grant(ok);
      req   = 2'b00;
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_req_db", 32'(data_break), 32'(0));
      chk("clr_req_gnt", 32'(gnt), 32'(0));
      chk("clr_req_err", 32'(timeout_err), 32'(0));
      repeat (3) step();
      chk("clr_req_idle", 32'(data_break), 32'(0));
    end

    // Reset during BRK restores rr_ptr to 0
    req_addr[0] = 15'o55555; req_data[0] = 12'o4444; req_to_dev[0] = 1'b0;
    sb.push_back('{0, 15'o55555, 12'o4444, 1'b0});
    req = 2'b01;
    run_cycle(0, 1'b0, 1'b0, 1'b0, 2'b01);
    begin
      bit ok;
      req = 2'b01;
      wait_grant(ok);
      req = 2'b00;
      step();
      cpu_state = CPU_DB1;
      step();
      cpu_state = '0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
      chk("brk_rst_gnt", 32'(gnt), 32'(0));
      chk("brk_rst_done", 32'(done), 32'(0));
      chk("brk_rst_db", 32'(data_break), 32'(0));
      chk("brk_rst_to_disk", 32'(to_disk), 32'(0));
      chk("brk_rst_addr", 32'(db_addr), 32'(0));
      chk("brk_rst_dout", 32'(db_dout), 32'(0));
      chk("brk_rst_err", 32'(timeout_err), 32'(0));
    end
    req_addr[0] = 15'o00007; req_data[0] = 12'o0070; req_to_dev[0] = 1'b1;
    req_addr[1] = 15'o07000; req_data[1] = 12'o7000; req_to_dev[1] = 1'b0;
    sb.push_back('{0, 15'o00007, 12'o0070, 1'b1});
    req = 2'b11;
    run_cycle(1, 1'b0, 1'b0, 1'b0, 2'b11);

    // Request inputs scrambled during BRK must not reach db_* outputs
    req_addr[1] = 15'o70707; req_data[1] = 12'o0123; req_to_dev[1] = 1'b1;
    sb.push_back('{1, 15'o70707, 12'o0123, 1'b1});
    req = 2'b10;
    run_cycle(2, 1'b0, 1'b0, 1'b1, 2'b10);

    repeat (3) step();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
